// File: rtl/ext_pipe.sv
// ext_pipe: registered multi-mode immediate extender feeding a 2-entry output FIFO.
// Define EXT_PIPE_ERR_EN to build the illegal-opcode flag (out_err) and saturating err_cnt.
module ext_pipe #(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32,
    parameter int SHAMT = 2,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IMM_W-1:0] in_imm,
    input  logic [2:0]       in_eop,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic [7:0]       err_cnt
);

    localparam int S = OUT_W - IMM_W;

    function automatic logic [OUT_W-1:0] extend(input logic [IMM_W-1:0] imm,
                                                input logic [2:0]       eop);
        logic [OUT_W-1:0] sext;
        logic [OUT_W-1:0] zext;
        sext = {{S{imm[IMM_W-1]}}, imm};
        zext = {{S{1'b0}}, imm};
        case (eop)
            3'b000:  extend = sext;
            3'b001:  extend = zext;
            3'b010:  extend = {imm, {S{1'b0}}};
            3'b011:  extend = sext << SHAMT;
            3'b100:  extend = zext << SHAMT;
            default: extend = {OUT_W{1'b0}};
        endcase
    endfunction

    logic [1:0]       count_r;
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [OUT_W-1:0] data_mem_r [2];
    logic [TAG_W-1:0] tag_mem_r  [2];
    logic [OUT_W-1:0] ext_s;
    logic             push_s;
    logic             pop_s;

    // in_ready depends only on registered count, so there is no path from out_ready.
    assign in_ready  = (count_r != 2'd2);
    assign out_valid = (count_r != 2'd0);
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;
    assign out_data  = data_mem_r[rd_ptr_r];
    assign out_tag   = tag_mem_r[rd_ptr_r];

    // Extension result computed at the input, captured on accept.
    always_comb begin
        ext_s = extend(in_imm, in_eop);
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r       <= 2'd0;
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            data_mem_r[0] <= {OUT_W{1'b0}};
            data_mem_r[1] <= {OUT_W{1'b0}};
            tag_mem_r[0]  <= {TAG_W{1'b0}};
            tag_mem_r[1]  <= {TAG_W{1'b0}};
        end else begin
            if (push_s) begin
                data_mem_r[wr_ptr_r] <= ext_s;
                tag_mem_r[wr_ptr_r]  <= in_tag;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef EXT_PIPE_ERR_EN
    logic       err_mem_r [2];
    logic [7:0] err_cnt_r;
    logic       illegal_s;

    assign illegal_s = (in_eop > 3'b100);
    assign out_err   = err_mem_r[rd_ptr_r];
    assign err_cnt   = err_cnt_r;

    // Per-entry error flag and saturating count of accepted illegal opcodes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_mem_r[0] <= 1'b0;
            err_mem_r[1] <= 1'b0;
            err_cnt_r    <= 8'd0;
        end else begin
            if (push_s) begin
                err_mem_r[wr_ptr_r] <= illegal_s;
            end
            if (push_s && illegal_s && (err_cnt_r != 8'd255)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end
        end
    end
`else
    assign out_err = 1'b0;
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: scoreboard on every output pop plus per-scenario checks.
// Expectations for out_err/err_cnt follow whether EXT_PIPE_ERR_EN is defined.
module tb_ext_pipe;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_imm = 16'h0;
    logic [2:0]  in_eop = 3'b000;
    logic [4:0]  in_tag = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_err;
    logic [7:0]  err_cnt;

    logic        p_in_valid = 1'b0;
    logic        p_in_ready;
    logic [7:0]  p_in_imm = 8'h0;
    logic [2:0]  p_in_eop = 3'b000;
    logic [4:0]  p_in_tag = 5'd0;
    logic        p_out_valid;
    logic        p_out_ready = 1'b1;
    logic [15:0] p_out_data;
    logic [4:0]  p_out_tag;
    logic        p_out_err;
    logic [7:0]  p_err_cnt;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    exp_t sb_head;
    logic [31:0] mode_exp [0:4] = '{32'hFFFF8001, 32'h00008001, 32'h80010000,
                                    32'hFFFE0004, 32'h00020004};

`ifdef EXT_PIPE_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    ext_pipe u_dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
        .in_eop(in_eop), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_err(out_err), .err_cnt(err_cnt)
    );

    ext_pipe #(.IMM_W(8), .OUT_W(16), .SHAMT(1), .TAG_W(5)) u_dut8 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(p_in_valid), .in_ready(p_in_ready), .in_imm(p_in_imm),
        .in_eop(p_in_eop), .in_tag(p_in_tag),
        .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data),
        .out_tag(p_out_tag), .out_err(p_out_err), .err_cnt(p_err_cnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] imm, input logic [2:0] eop,
                                   input logic [4:0] tag);
        exp_t e;
        logic signed [31:0] sx;
        logic [31:0] zx;
        sx = $signed(imm);
        zx = {16'h0000, imm};
        case (eop)
            3'd0:    e.data = sx;
            3'd1:    e.data = zx;
            3'd2:    e.data = zx * 32'd65536;
            3'd3:    e.data = sx * 32'sd4;
            3'd4:    e.data = zx * 32'd4;
            default: e.data = 32'h0;
        endcase
        e.tag = tag;
        e.err = ERR_ON && (eop >= 3'd5);
        return e;
    endfunction

    // Scoreboard: record accepted ops, compare every popped head in order.
    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_pop: got data %h tag %0d, expected no output", out_data, out_tag);
                end else begin
                    sb_head = sb_q.pop_front();
                    if ({out_data, out_tag, out_err} !== sb_head) begin
                        n_fail++;
                        $display("FAIL sb_compare: got %h/%0d/%b, expected %h/%0d/%b",
                                 out_data, out_tag, out_err, sb_head.data, sb_head.tag, sb_head.err);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(model(in_imm, in_eop, in_tag));
            end
        end
    end

    task automatic send(input logic [15:0] imm, input logic [2:0] eop, input logic [4:0] tag);
        int waited = 0;
        in_valid = 1'b1;
        in_imm   = imm;
        in_eop   = eop;
        in_tag   = tag;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL send_timeout: in_ready %b after %0d cycles, expected 1", in_ready, waited);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d pending, out_valid %b, expected 0 pending and 0", name, sb_q.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({out_valid, in_ready, out_data, out_tag, out_err, err_cnt} !== {1'b0, 1'b1, 32'h0, 5'd0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got v%b r%b d%h t%0d e%b c%0d, expected v0 r1 d0 t0 e0 c0",
                     out_valid, in_ready, out_data, out_tag, out_err, err_cnt);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_modes();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(16'h8001, i[2:0], i[4:0] + 5'd1);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== mode_exp[i]) begin
                n_fail++;
                $display("FAIL mode_%0d: got %h valid %b, expected %h valid 1", i, out_data, out_valid, mode_exp[i]);
            end
        end
        drain("modes");
    endtask

    task automatic test_back_to_back();
        logic [4:0] tg;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tg = 5'(i + 8);
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_in_ready_%0d: got %b, expected 1", i, in_ready);
            end
            send(16'($urandom), 3'(i % 5), tg);
            n_checks++;
            if (out_valid !== 1'b1 || out_tag !== tg) begin
                n_fail++;
                $display("FAIL stream_latency_%0d: got valid %b tag %0d, expected 1 and %0d", i, out_valid, out_tag, tg);
            end
        end
        drain("stream");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(16'h0011, 3'd0, 5'd1);
        send(16'h0022, 3'd1, 5'd2);
        in_imm = 16'h0033;
        in_eop = 3'd2;
        in_tag = 5'd3;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 5'd1 || out_data !== 32'h00000011) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got r%b v%b t%0d d%h, expected r0 v1 t1 d00000011",
                         i, in_ready, out_valid, out_tag, out_data);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_tag !== 5'd2) begin
            n_fail++;
            $display("FAIL bp_release: got r%b t%0d, expected r1 t2", in_ready, out_tag);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_tag !== 5'd3 || out_data !== 32'h00330000) begin
            n_fail++;
            $display("FAIL bp_third: got v%b t%0d d%h, expected v1 t3 d00330000", out_valid, out_tag, out_data);
        end
        drain("bp");
    endtask

    task automatic test_push_pop();
        out_ready = 1'b0;
        send(16'hA5A5, 3'd0, 5'd9);
        out_ready = 1'b1;
        send(16'h1234, 3'd1, 5'd10);
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_tag !== 5'd10 || out_data !== 32'h00001234) begin
            n_fail++;
            $display("FAIL pushpop_count1: got v%b r%b t%0d d%h, expected v1 r1 t10 d00001234",
                     out_valid, in_ready, out_tag, out_data);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pushpop_empty: got valid %b, expected 0", out_valid);
        end
        drain("pushpop");
    endtask

    task automatic test_err();
        out_ready = 1'b1;
        send(16'hFFFF, 3'b111, 5'd7);
        n_checks++;
        if (out_data !== 32'h0 || out_err !== ERR_ON) begin
            n_fail++;
            $display("FAIL err_illegal: got d%h err %b, expected d0 err %b", out_data, out_err, ERR_ON);
        end
        for (int i = 0; i < 300; i++) begin
            send(16'($urandom), 3'(5 + $urandom_range(0, 2)), 5'(i));
        end
        in_valid = 1'b0;
        n_checks++;
        if (err_cnt !== (ERR_ON ? 8'd255 : 8'd0)) begin
            n_fail++;
            $display("FAIL err_cnt_sat: got %0d, expected %0d", err_cnt, ERR_ON ? 255 : 0);
        end
        drain("err");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(16'h7FFF, 3'd0, 5'd20);
        send(16'h0F0F, 3'd4, 5'd21);
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_full: got v%b r%b, expected v1 r0", out_valid, in_ready);
        end
        #2;
        reset_n = 1'b0;
        #1;
        sb_q.delete();
        n_checks++;
        if ({out_valid, in_ready, out_data, out_err, err_cnt} !== {1'b0, 1'b1, 32'h0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL rmid_reset: got v%b r%b d%h e%b c%0d, expected v0 r1 d0 e0 c0",
                     out_valid, in_ready, out_data, out_err, err_cnt);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_after: got v%b r%b, expected v0 r1", out_valid, in_ready);
        end
    endtask

    task automatic test_params();
        p_out_ready = 1'b1;
        p_in_valid  = 1'b1;
        p_in_imm    = 8'hC0;
        p_in_eop    = 3'b011;
        p_in_tag    = 5'd3;
        @(posedge clk);
        #1;
        n_checks++;
        if (p_out_valid !== 1'b1 || p_out_data !== 16'hFF80 || p_out_tag !== 5'd3) begin
            n_fail++;
            $display("FAIL param_sext_shl: got v%b d%h t%0d, expected v1 dFF80 t3", p_out_valid, p_out_data, p_out_tag);
        end
        p_in_eop = 3'b010;
        p_in_tag = 5'd4;
        @(posedge clk);
        #1;
        p_in_valid = 1'b0;
        n_checks++;
        if (p_out_valid !== 1'b1 || p_out_data !== 16'hC000 || p_out_tag !== 5'd4) begin
            n_fail++;
            $display("FAIL param_upper: got v%b d%h t%0d, expected v1 dC000 t4", p_out_valid, p_out_data, p_out_tag);
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_back_to_back();
        test_backpressure();
        test_push_pop();
        test_err();
        test_reset_mid();
        test_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
